// File: rtl/bit_stream_tx_pkg.sv
// Shared constants and state encoding for the LED bit-stream transmitter.
package bit_stream_tx_pkg;

    localparam int BST_WIDTH = 18;
    localparam int BST_LEN_W = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/bit_stream_tx_counter.sv
// Bit index down-counter: load, decrement, hold, zero flag.
module bit_down_counter
    import bit_stream_tx_pkg::*;
#(
    parameter int LEN_W = BST_LEN_W
) (
    input  logic             clk1,
    input  logic             reset,
    input  logic             load,
    input  logic [LEN_W-1:0] load_val,
    input  logic             dec,
    output logic [LEN_W-1:0] count,
    output logic             zero
);

    // load wins over dec; neither asserted holds the count
    always_ff @(posedge clk1 or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec) begin
            count <= count - LEN_W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/bit_stream_tx.sv
// Serialises a latched pattern MSB-first onto n, one bit per clk1 cycle.
// Define BIT_STREAM_TX_REPEAT_EN to add the repeat_en loop input.
module bit_stream_tx
    import bit_stream_tx_pkg::*;
#(
    parameter int WIDTH = BST_WIDTH,
    parameter int LEN_W = BST_LEN_W
) (
    input  logic             clk1,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] pattern,
    input  logic [LEN_W-1:0] len,
    input  logic             hold,
`ifdef BIT_STREAM_TX_REPEAT_EN
    // "repeat" is a reserved word, hence repeat_en
    input  logic             repeat_en,
`endif
    output logic             n,
    output logic             bit_valid,
    output logic             busy,
    output logic             done,
    output logic [LEN_W-1:0] bit_idx,
    output state_t           dbg_state
);

    // Stream handshake: a bit is transferred in every cycle where bit_valid=1.
    // hold sampled high on an edge freezes n/bit_idx and drops bit_valid for
    // the following cycle; the stream resumes with the next bit once hold=0.

    state_t           state_q, state_d;
    logic             n_q, n_d;
    logic             valid_q, valid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] pat_q;
    logic [LEN_W-1:0] len_q;
    logic             latch;
    logic             cnt_load, cnt_dec, cnt_zero;
    logic [LEN_W-1:0] cnt_load_val, count;
    logic [LEN_W-1:0] len_eff;
    logic             rep;

`ifdef BIT_STREAM_TX_REPEAT_EN
    assign rep = repeat_en;
`else
    assign rep = 1'b0;
`endif

    function automatic logic pick(input logic [WIDTH-1:0] v, input logic [LEN_W-1:0] i);
        logic [WIDTH-1:0] s;
        s = v >> i;
        return s[0];
    endfunction

    assign len_eff = (len > LEN_W'(WIDTH)) ? LEN_W'(WIDTH) : len;

    bit_down_counter #(.LEN_W(LEN_W)) u_cnt (
        .clk1     (clk1),
        .reset    (reset),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .dec      (cnt_dec),
        .count    (count),
        .zero     (cnt_zero)
    );

    always_comb begin
        state_d      = state_q;
        n_d          = 1'b0;
        valid_d      = 1'b0;
        done_d       = 1'b0;
        latch        = 1'b0;
        cnt_load     = 1'b0;
        cnt_dec      = 1'b0;
        cnt_load_val = len_eff - LEN_W'(1);
        case (state_q)
            IDLE: begin
                if (start && (len != '0)) begin
                    latch        = 1'b1;
                    cnt_load     = 1'b1;
                    cnt_load_val = len_eff - LEN_W'(1);
                    n_d          = pick(pattern, len_eff - LEN_W'(1));
                    valid_d      = 1'b1;
                    state_d      = SHIFT;
                end
            end
            SHIFT: begin
                if (hold) begin
                    n_d = n_q;
                end else if (cnt_zero) begin
                    if (rep) begin
                        cnt_load     = 1'b1;
                        cnt_load_val = len_q - LEN_W'(1);
                        n_d          = pick(pat_q, len_q - LEN_W'(1));
                        valid_d      = 1'b1;
                    end else begin
                        done_d  = 1'b1;
                        state_d = DONE;
                    end
                end else begin
                    cnt_dec = 1'b1;
                    n_d     = pick(pat_q, count - LEN_W'(1));
                    valid_d = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk1 or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            n_q     <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pat_q   <= '0;
            len_q   <= '0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            if (latch) begin
                pat_q <= pattern;
                len_q <= len_eff;
            end
        end
    end

    assign n         = n_q;
    assign bit_valid = valid_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign bit_idx   = count;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_bit_stream_tx.sv
// Directed bench for bit_stream_tx; inputs change and outputs are checked on negedge.
module tb_bit_stream_tx;
    import bit_stream_tx_pkg::*;

    localparam int WIDTH = 18;
    localparam int LEN_W = 5;

    logic             clk1 = 1'b0;
    logic             reset, start, hold;
    logic [WIDTH-1:0] pattern;
    logic [LEN_W-1:0] len;
    logic             n, bit_valid, busy, done;
    logic [LEN_W-1:0] bit_idx;
    state_t           dbg_state;
`ifdef BIT_STREAM_TX_REPEAT_EN
    logic             repeat_en;
`endif

    int               errors = 0;
    int               checks = 0;
    logic [0:0]       exp_q[$];
    logic [WIDTH-1:0] ev;

    always #5 clk1 = ~clk1;

    bit_stream_tx dut (
        .clk1      (clk1),
        .reset     (reset),
        .start     (start),
        .pattern   (pattern),
        .len       (len),
        .hold      (hold),
`ifdef BIT_STREAM_TX_REPEAT_EN
        .repeat_en (repeat_en),
`endif
        .n         (n),
        .bit_valid (bit_valid),
        .busy      (busy),
        .done      (done),
        .bit_idx   (bit_idx),
        .dbg_state (dbg_state)
    );

    task automatic tick();
        @(negedge clk1);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_quiet(input string tag, input logic exp_busy);
        chk({tag, "_n"},     32'(n), 0);
        chk({tag, "_valid"}, 32'(bit_valid), 0);
        chk({tag, "_done"},  32'(done), 0);
        chk({tag, "_busy"},  32'(busy), 32'(exp_busy));
    endtask

    // Checks nbits valid bits; optionally holds for hold_n cycles after bit hold_at.
    task automatic run_bits(input logic [WIDTH-1:0] exp_bits, input int nbits,
                            input int hold_at, input int hold_n);
        logic [0:0] b;
        for (int i = nbits - 1; i >= 0; i--) exp_q.push_back(exp_bits[i]);
        for (int i = nbits - 1; i >= 0; i--) begin
            b = exp_q.pop_front();
            chk("bit_valid", 32'(bit_valid), 1);
            chk("n",         32'(n), 32'(b));
            chk("bit_idx",   32'(bit_idx), i);
            chk("busy",      32'(busy), 1);
            chk("done_mid",  32'(done), 0);
            if (hold_n > 0 && (nbits - i) == hold_at) begin
                hold = 1'b1;
                for (int h = 0; h < hold_n; h++) begin
                    tick();
                    chk("hold_valid", 32'(bit_valid), 0);
                    chk("hold_n",     32'(n), 32'(b));
                    chk("hold_idx",   32'(bit_idx), i);
                end
                hold = 1'b0;
            end
            tick();
        end
    endtask

    // Expects the DONE cycle now, then the IDLE cycle after one edge.
    task automatic done_checks();
        chk("done_pulse", 32'(done), 1);
        chk("done_valid", 32'(bit_valid), 0);
        chk("done_n",     32'(n), 0);
        chk("done_busy",  32'(busy), 1);
        chk("done_state", 32'(dbg_state), 32'(DONE));
        tick();
        chk_quiet("after_done", 1'b0);
        chk("after_done_state", 32'(dbg_state), 32'(IDLE));
    endtask

    initial begin
        reset   = 1'b1;
        start   = 1'b0;
        hold    = 1'b0;
        pattern = '0;
        len     = '0;
`ifdef BIT_STREAM_TX_REPEAT_EN
        repeat_en = 1'b0;
`endif
        tick();
        chk_quiet("reset", 1'b0);
        chk("reset_idx",   32'(bit_idx), 0);
        chk("reset_state", 32'(dbg_state), 32'(IDLE));
        reset = 1'b0;
        tick();
        chk_quiet("post_reset", 1'b0);

        // full 18-bit frame
        pattern = 18'h2A5C3; len = 5'd18; start = 1'b1;
        tick();
        start = 1'b0;
        run_bits(18'b10_1010_0101_1100_0011, 18, 0, 0);
        done_checks();

        // 4-bit frame with a 2-cycle hold after the 2nd bit
        pattern = 18'h0000B; len = 5'd4; start = 1'b1;
        tick();
        start = 1'b0;
        run_bits(18'b1011, 4, 2, 2);
        done_checks();

        // len=0 ignored
        pattern = 18'h3FFFF; len = 5'd0; start = 1'b1;
        tick();
        chk_quiet("len0_a", 1'b0);
        chk("len0_state", 32'(dbg_state), 32'(IDLE));
        tick();
        chk_quiet("len0_b", 1'b0);
        start = 1'b0;

        // len=25 clamps to 18 bits
        pattern = 18'h12345; len = 5'd25; start = 1'b1;
        tick();
        start = 1'b0;
        run_bits(18'b01_0010_0011_0100_0101, 18, 0, 0);
        done_checks();

        // reset after the 5th bit
        ev = 18'b10_1010_0101_1100_0011;
        pattern = 18'h2A5C3; len = 5'd18; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 17; i >= 13; i--) begin
            chk("pre_rst_n",   32'(n), 32'(ev[i]));
            chk("pre_rst_idx", 32'(bit_idx), i);
            if (i > 13) tick();
        end
        reset = 1'b1;
        tick();
        chk_quiet("mid_reset", 1'b0);
        chk("mid_reset_idx",   32'(bit_idx), 0);
        chk("mid_reset_state", 32'(dbg_state), 32'(IDLE));
        reset = 1'b0;
        pattern = 18'h15555; len = 5'd18; start = 1'b1;
        tick();
        start = 1'b0;
        run_bits(18'b01_0101_0101_0101_0101, 18, 0, 0);
        done_checks();

        // start held high; pattern changed mid-frame
        pattern = 18'h0000B; len = 5'd4; start = 1'b1;
        tick();
        pattern = 18'h3FFF4;
        run_bits(18'b1011, 4, 0, 0);
        done_checks();
        tick();
        start = 1'b0;
        run_bits(18'b0100, 4, 0, 0);
        done_checks();

`ifdef BIT_STREAM_TX_REPEAT_EN
        // gapless loop of 110, then drop repeat
        repeat_en = 1'b1; pattern = 18'b110; len = 5'd3; start = 1'b1;
        tick();
        start = 1'b0;
        ev = 18'b110;
        for (int k = 0; k < 3; k++) begin
            for (int i = 2; i >= 0; i--) begin
                chk("rep_valid", 32'(bit_valid), 1);
                chk("rep_n",     32'(n), 32'(ev[i]));
                chk("rep_idx",   32'(bit_idx), i);
                chk("rep_done",  32'(done), 0);
                tick();
            end
        end
        repeat_en = 1'b0;
        run_bits(18'b110, 3, 0, 0);
        done_checks();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bit_stream_tx.md
BIT_STREAM_TX -- requirements
Module: bit_stream_tx

Interface
REQ-001 SHALL have parameter WIDTH, default 18, giving the maximum pattern length in bits (one bit per LED).
REQ-002 SHALL have parameter LEN_W, default 5, giving the width of the length field.
REQ-003 SHALL have port clk1  in  1  clock; all state SHALL update on the rising edge.
REQ-004 SHALL have port reset  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have port start  in  1  request to load and send one frame, sampled in IDLE only.
REQ-006 SHALL have port pattern  in  WIDTH  parallel pattern, sent MSB-first from bit len-1 down to bit 0.
REQ-007 SHALL have port len  in  LEN_W  number of bits to send.
REQ-008 SHALL have port hold  in  1  stall; freezes transmission while high.
REQ-009 SHALL have port n  out  1  serial data bit, the stream a downstream shift register consumes.
REQ-010 SHALL have port bit_valid  out  1  n holds a valid bit this cycle.
REQ-011 SHALL have port busy  out  1  high from the cycle after an accepted start until DONE is left.
REQ-012 SHALL have port done  out  1  one-cycle pulse after the last bit of a frame.
REQ-013 SHALL have port bit_idx  out  LEN_W  index of the bit currently on n.

Function
REQ-014 SHALL implement the states IDLE, SHIFT and DONE, registered and binary-encoded.
REQ-015 In IDLE with start=1, SHALL latch pattern and the effective length into internal registers and go to SHIFT on the next edge.
- Effective length = len if 1..WIDTH.
- Effective length = WIDTH if len > WIDTH.
REQ-016 In IDLE with start=1 and len=0, SHALL ignore the request, stay in IDLE and pulse no done.
REQ-017 The first bit SHALL appear one cycle after start was sampled, with bit_valid=1, n=pattern[len_eff-1] and bit_idx=len_eff-1.
REQ-018 In SHIFT with hold=0, SHALL present one bit per clk1 cycle, decrementing bit_idx each cycle.
REQ-019 In SHIFT with hold=1, SHALL keep n and bit_idx frozen and drive bit_valid=0; no bit is lost or repeated.
REQ-020 When bit_idx=0 is sent with hold=0, SHALL go to DONE; DONE SHALL assert done=1 for exactly one cycle, then return to IDLE.
REQ-021 SHALL ignore start in SHIFT and DONE; the latched pattern and length SHALL not change mid-frame.
REQ-022 A start sampled in the IDLE cycle right after DONE SHALL be accepted, so the gap between frames is 2 cycles.
REQ-023 SHALL drive n=0 and bit_valid=0 in IDLE and DONE.
REQ-024 All outputs SHALL be registered; there is no combinational path from inputs to outputs.

Reset
REQ-025 Reset high SHALL force IDLE and clear n, bit_valid, busy, done, bit_idx and the latched pattern and length to 0, including mid-frame.
REQ-026 After reset is released, the first edge with start=1 SHALL be accepted normally.

Configuration
REQ-027 With macro BIT_STREAM_TX_REPEAT_EN defined, SHALL add input port repeat (1 bit).
- If repeat=1 when the last bit is sent, SHALL reload bit_idx=len_eff-1 and stay in SHIFT with no done pulse, giving a gapless loop.
- If repeat=0 at that point, SHALL go to DONE as normal.
REQ-028 Without BIT_STREAM_TX_REPEAT_EN, the port repeat and its logic SHALL be absent, and behaviour SHALL equal repeat=0.

Structure
REQ-029 A shared package SHALL hold WIDTH, LEN_W and the state encoding constants (IDLE=0, SHIFT=1, DONE=2).
REQ-030 The bit index down-counter (load, decrement, hold, zero flag) SHALL be one sub-module, bit_down_counter; the state machine and data path stay in bit_stream_tx.

Verification
REQ-031 start=1, pattern=18'h2A5C3, len=18, hold=0 -> bit_valid high for 18 cycles starting 1 cycle after start; n sequence 10_1010_0101_1100_0011; done pulses once on the cycle after the last bit.
REQ-032 pattern=18'h0000B, len=4, hold=1 for 2 cycles after the 2nd bit -> n sequence 1011 with 2 bit_valid=0 gaps; done pulses after the 4th bit.
REQ-033 len=0 with start=1 -> stays IDLE, busy=0, no done; len=25 -> exactly 18 bits sent.
REQ-034 Reset pulsed after the 5th bit of an 18-bit frame -> all outputs 0 on the next edge; a new start then sends a full frame.
REQ-035 start held high through a frame -> new frame begins 2 cycles after done; pattern changes during SHIFT do not affect n.
REQ-036 With BIT_STREAM_TX_REPEAT_EN, len=3, pattern=3'b110, repeat=1 -> n loops 110110110… with no gaps and no done; drop repeat -> done after the current frame.
